// File: rtl/ahb2apb_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
package ahb2apb_bridge_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StSetup,
      StAccess,
      StDone,
      StErr1,
      StErr2
   } state_e;

   localparam logic [1:0] HrespOkay  = 2'b00;
   localparam logic [1:0] HrespError = 2'b01;

   // Peripheral window index lives in haddr[18:16], 64KB per peripheral.
   localparam int unsigned WinLsb = 16;
   localparam int unsigned WinW   = 3;

   function automatic logic [WinW-1:0] win_idx(input logic [31:0] addr);
      return addr[WinLsb +: WinW];
   endfunction

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// Fabric-side AHB-Lite port s2 plus the APB3 peripheral bus of the bridge.
interface ahb2apb_bridge_if #(
   parameter int unsigned NUM_SLV = 8
);
   logic                   hsel_s2;
   logic [31:0]            haddr_s2;
   logic                   hwrite_s2;
   logic [31:0]            hwdata_s2;
   logic                   hready_s2;
   logic [1:0]             hresp_s2;
   logic [31:0]            hrdata_s2;
   logic [31:0]            paddr;
   logic                   pwrite;
   logic [31:0]            pwdata;
   logic [NUM_SLV-1:0]     psel;
   logic                   penable;
   logic [NUM_SLV*32-1:0]  prdata;
   logic [NUM_SLV-1:0]     pready;
   logic [NUM_SLV-1:0]     pslverr;

   // Bridge view: AHB slave, APB master.
   modport slave (
      input  hsel_s2, haddr_s2, hwrite_s2, hwdata_s2, prdata, pready, pslverr,
      output hready_s2, hresp_s2, hrdata_s2, paddr, pwrite, pwdata, psel, penable
   );

   // Environment view: fabric master and the peripherals.
   modport master (
      output hsel_s2, haddr_s2, hwrite_s2, hwdata_s2, prdata, pready, pslverr,
      input  hready_s2, hresp_s2, hrdata_s2, paddr, pwrite, pwdata, psel, penable
   );

endinterface

// File: rtl/ahb2apb_bridge_timeout_cnt.sv
// Counts ACCESS cycles with pready low and flags a hung peripheral.
module ahb2apb_bridge_timeout_cnt #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic pll_core_cpuclk,
   input  logic pad_cpu_rst_b,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int unsigned     CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit              Enabled = (TIMEOUT != 0);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Clear on ACCESS entry, count stalled cycles, saturate at TIMEOUT.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The stalled cycle being counted now is the TIMEOUT-th one.
   assign expire_o = Enabled && enable_i && (cnt_q >= CntLast);

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave on fabric port s2 turning each transfer into one APB3 transfer.
module ahb2apb_bridge
   import ahb2apb_bridge_pkg::*;
#(
   parameter int unsigned NUM_SLV = 8,  // 1..8
   parameter int unsigned TIMEOUT = 256 // 0 disables the hung-peripheral timeout
) (
   input logic             pll_core_cpuclk,
   input logic             pad_cpu_rst_b,
   ahb2apb_bridge_if.slave bus
);

   state_e              state_q, state_d;
   logic [WinW-1:0]     idx_q, idx_d;
   logic                hready_q, hready_d;
   logic [1:0]          hresp_q, hresp_d;
   logic [31:0]         hrdata_q, hrdata_d;
   logic [31:0]         paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [31:0]         pwdata_q, pwdata_d;
   logic [NUM_SLV-1:0]  psel_q, psel_d;
   logic                penable_q, penable_d;

   logic                sel_ready, sel_err, tmo_expire;
   logic [31:0]         sel_rdata;

   // Pick the response of the addressed peripheral; the others are ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == WinW'(i)) begin
            sel_ready = bus.pready[i];
            sel_err   = bus.pslverr[i];
            sel_rdata = bus.prdata[32*i +: 32];
         end
      end
   end

   ahb2apb_bridge_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .pll_core_cpuclk (pll_core_cpuclk),
      .pad_cpu_rst_b   (pad_cpu_rst_b),
      .clear_i         (state_q == StSetup),
      .enable_i        ((state_q == StAccess) && !sel_ready),
      .expire_o        (tmo_expire)
   );

   // Next state and next registered outputs of the bridge FSM.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      hready_d  = hready_q;
      hresp_d   = hresp_q;
      hrdata_d  = hrdata_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      unique case (state_q)
         // DONE and ERR2 accept a new transfer exactly like IDLE does.
         StIdle, StDone, StErr2: begin
            state_d  = StIdle;
            hready_d = 1'b1;
            hresp_d  = HrespOkay;
            if (bus.hsel_s2) begin
               state_d  = StLatch;
               hready_d = 1'b0;
               idx_d    = win_idx(bus.haddr_s2);
               paddr_d  = {16'b0, bus.haddr_s2[15:0]};
               pwrite_d = bus.hwrite_s2;
            end
         end
         StLatch: begin
            pwdata_d = bus.hwdata_s2;
            if (32'(idx_q) >= NUM_SLV) begin
               state_d = StErr1;
               hresp_d = HrespError;
            end else begin
               state_d = StSetup;
               psel_d  = NUM_SLV'(1) << idx_q;
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
         end
         StAccess: begin
            if (sel_ready) begin
               psel_d    = '0;
               penable_d = 1'b0;
               if (!pwrite_q) begin
                  hrdata_d = sel_rdata;
               end
               if (sel_err) begin
                  state_d = StErr1;
                  hresp_d = HrespError;
               end else begin
                  state_d  = StDone;
                  hready_d = 1'b1;
               end
            end else if (tmo_expire) begin
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = StErr1;
               hresp_d   = HrespError;
            end
         end
         StErr1: begin
            state_d  = StErr2;
            hready_d = 1'b1;
         end
         default: begin
            state_d  = StIdle;
            hready_d = 1'b1;
            hresp_d  = HrespOkay;
            psel_d   = '0;
            penable_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         hready_q  <= 1'b1;
         hresp_q   <= HrespOkay;
         hrdata_q  <= '0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         hready_q  <= hready_d;
         hresp_q   <= hresp_d;
         hrdata_q  <= hrdata_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
      end
   end

   assign bus.hready_s2 = hready_q;
   assign bus.hresp_s2  = hresp_q;
   assign bus.hrdata_s2 = hrdata_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;

`ifndef SYNTHESIS
   // The fabric never selects us while a transfer is still in flight.
   logic busy;
   assign busy = state_q inside {StLatch, StSetup, StAccess, StErr1};
   hsel_when_busy_a: assert property (@(posedge pll_core_cpuclk) disable iff (!pad_cpu_rst_b)
      !(bus.hsel_s2 && busy));
`endif

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Scoreboard bench: dut8 (8 peripherals, TIMEOUT 256) and dut4 (4 peripherals, TIMEOUT 4).
module tb_ahb2apb_bridge;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   ahb2apb_bridge_if #(.NUM_SLV(8)) if8 ();
   ahb2apb_bridge_if #(.NUM_SLV(4)) if4 ();

   ahb2apb_bridge #(.NUM_SLV(8), .TIMEOUT(256)) u_dut8 (
      .pll_core_cpuclk (clk),
      .pad_cpu_rst_b   (rst_b),
      .bus             (if8)
   );

   ahb2apb_bridge #(.NUM_SLV(4), .TIMEOUT(4)) u_dut4 (
      .pll_core_cpuclk (clk),
      .pad_cpu_rst_b   (rst_b),
      .bus             (if4)
   );

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          lat;
      int          issue;
   } ahb_exp_t;

   typedef struct {
      logic [7:0]  psel;
      logic [31:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      int          acc;
   } apb_exp_t;

   ahb_exp_t ahb_q0[$], ahb_q1[$];
   apb_exp_t apb_q0[$], apb_q1[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   int         acc_cnt[2];
   int         wait_c[2];
   bit         err_c[2];
   bit         hang_c[2];
   logic       prev_rdy[2];
   logic [1:0] prev_resp[2];
   bit         apb_act[2];
   int         apb_acc[2];
   apb_exp_t   apb_cur[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic fail_evt(string name);
      n_checks++;
      $display("FAIL %s: event seen, expected none", name);
   endtask

   // Peripheral models: selected slave waits wait_c ACCESS cycles; unselected lines held high.
   always @(negedge clk) begin
      logic rdy;
      if (if8.penable && if8.psel != 0) begin
         rdy = (acc_cnt[0] >= wait_c[0]) && !hang_c[0];
         acc_cnt[0]++;
      end else begin
         rdy = 1'b0;
         acc_cnt[0] = 0;
      end
      if8.pready  = ~if8.psel | (rdy ? if8.psel : 8'h00);
      if8.pslverr = ~if8.psel | ((rdy && err_c[0]) ? if8.psel : 8'h00);
   end

   always @(negedge clk) begin
      logic rdy;
      if (if4.penable && if4.psel != 0) begin
         rdy = (acc_cnt[1] >= wait_c[1]) && !hang_c[1];
         acc_cnt[1]++;
      end else begin
         rdy = 1'b0;
         acc_cnt[1] = 0;
      end
      if4.pready  = ~if4.psel | (rdy ? if4.psel : 4'h0);
      if4.pslverr = ~if4.psel | ((rdy && err_c[1]) ? if4.psel : 4'h0);
   end

   // AHB monitor: a rising hready ends a transfer; compare against the scoreboard.
   task automatic mon_ahb(int d, logic hready, logic [1:0] hresp, logic [31:0] hrdata);
      ahb_exp_t e;
      int       sz;
      if (!rst_b) begin
         prev_rdy[d]  = 1'b1;
         prev_resp[d] = 2'b00;
         return;
      end
      if (hready && !prev_rdy[d]) begin
         sz = (d == 0) ? ahb_q0.size() : ahb_q1.size();
         if (sz == 0) begin
            fail_evt($sformatf("ahb_unexpected_done_dut%0d", d));
         end else begin
            if (d == 0) e = ahb_q0.pop_front();
            else        e = ahb_q1.pop_front();
            chk($sformatf("hresp_dut%0d", d), {30'b0, hresp}, {30'b0, e.resp});
            chk($sformatf("hresp_prev_cycle_dut%0d", d), {30'b0, prev_resp[d]}, {30'b0, e.resp});
            chk($sformatf("hrdata_dut%0d", d), hrdata, e.rdata);
            chk($sformatf("latency_dut%0d", d), cyc - e.issue, e.lat);
         end
      end
      prev_rdy[d]  = hready;
      prev_resp[d] = hresp;
   endtask

   // APB monitor: check SETUP against the scoreboard, hold stable through ACCESS.
   task automatic mon_apb(int d, logic [7:0] psel, logic pen, logic [31:0] paddr, logic pwrite,
                          logic [31:0] pwdata);
      apb_exp_t e;
      int       sz;
      if (psel != 0 && !pen) begin
         sz = (d == 0) ? apb_q0.size() : apb_q1.size();
         if (sz == 0) begin
            fail_evt($sformatf("apb_unexpected_setup_dut%0d", d));
         end else begin
            if (d == 0) e = apb_q0.pop_front();
            else        e = apb_q1.pop_front();
            apb_cur[d] = e;
            apb_act[d] = 1'b1;
            apb_acc[d] = 0;
            chk($sformatf("setup_psel_dut%0d", d), {24'b0, psel}, {24'b0, e.psel});
            chk($sformatf("setup_paddr_dut%0d", d), paddr, e.paddr);
            chk($sformatf("setup_pwrite_dut%0d", d), {31'b0, pwrite}, {31'b0, e.pwrite});
            chk($sformatf("setup_pwdata_dut%0d", d), pwdata, e.pwdata);
         end
      end else if (pen) begin
         if (!apb_act[d] || psel == 0) begin
            fail_evt($sformatf("penable_outside_access_dut%0d", d));
         end else begin
            apb_acc[d]++;
            chk($sformatf("access_psel_dut%0d", d), {24'b0, psel}, {24'b0, apb_cur[d].psel});
            chk($sformatf("access_paddr_dut%0d", d), paddr, apb_cur[d].paddr);
            chk($sformatf("access_pwdata_dut%0d", d), pwdata, apb_cur[d].pwdata);
         end
      end else if (apb_act[d]) begin
         apb_act[d] = 1'b0;
         chk($sformatf("access_cycles_dut%0d", d), apb_acc[d], apb_cur[d].acc);
      end
   endtask

   always @(negedge clk) begin
      mon_ahb(0, if8.hready_s2, if8.hresp_s2, if8.hrdata_s2);
      mon_apb(0, if8.psel, if8.penable, if8.paddr, if8.pwrite, if8.pwdata);
      mon_ahb(1, if4.hready_s2, if4.hresp_s2, if4.hrdata_s2);
      mon_apb(1, 8'(if4.psel), if4.penable, if4.paddr, if4.pwrite, if4.pwdata);
   end

   // Present hsel for one cycle (called at a negedge), then hwdata in LATCH.
   task automatic start(int d, logic [31:0] a, logic w, logic [31:0] wd);
      if (d == 0) begin
         if8.hsel_s2 = 1'b1; if8.haddr_s2 = a; if8.hwrite_s2 = w;
      end else begin
         if4.hsel_s2 = 1'b1; if4.haddr_s2 = a; if4.hwrite_s2 = w;
      end
      @(posedge clk);
      #1;
      if (d == 0) begin
         if8.hsel_s2 = 1'b0; if8.hwdata_s2 = wd;
      end else begin
         if4.hsel_s2 = 1'b0; if4.hwdata_s2 = wd;
      end
   endtask

   // Push hand-computed expectations (psel==0 means no APB phase) and issue.
   task automatic xfer(int d, logic [31:0] a, logic w, logic [31:0] wd, logic [1:0] resp,
                       logic [31:0] rdata, int lat, logic [7:0] psel, logic [31:0] paddr, int acc);
      ahb_exp_t ea;
      apb_exp_t ep;
      ea = '{resp: resp, rdata: rdata, lat: lat, issue: cyc};
      ep = '{psel: psel, paddr: paddr, pwrite: w, pwdata: wd, acc: acc};
      if (d == 0) ahb_q0.push_back(ea);
      else        ahb_q1.push_back(ea);
      if (psel != 0) begin
         if (d == 0) apb_q0.push_back(ep);
         else        apb_q1.push_back(ep);
      end
      start(d, a, w, wd);
   endtask

   // Returns at the negedge where hready_s2 is back high.
   task automatic wait_done(int d);
      int   n = 0;
      logic r;
      do begin
         @(negedge clk);
         n++;
         r = (d == 0) ? if8.hready_s2 : if4.hready_s2;
      end while (!r && n < 100);
      if (!r) fail_evt($sformatf("wait_done_timeout_dut%0d", d));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_b = 1'b0;
      if8.hsel_s2 = 1'b0; if8.haddr_s2 = '0; if8.hwrite_s2 = 1'b0; if8.hwdata_s2 = '0;
      if4.hsel_s2 = 1'b0; if4.haddr_s2 = '0; if4.hwrite_s2 = 1'b0; if4.hwdata_s2 = '0;
      if8.pready = '1; if8.pslverr = '0;
      if4.pready = '1; if4.pslverr = '0;
      for (int i = 0; i < 8; i++) if8.prdata[32*i +: 32] = 32'hA5A5_0001 + i;
      for (int i = 0; i < 4; i++) if4.prdata[32*i +: 32] = 32'hA5A5_0001 + i;
      for (int i = 0; i < 2; i++) begin
         wait_c[i] = 0; err_c[i] = 1'b0; hang_c[i] = 1'b0; acc_cnt[i] = 0;
         prev_rdy[i] = 1'b1; prev_resp[i] = 2'b00; apb_act[i] = 1'b0; apb_acc[i] = 0;
      end
      repeat (2) @(negedge clk);
      #1 rst_b = 1'b1;
      @(negedge clk);

      chk("rst_hready", {31'b0, if8.hready_s2}, 32'd1);
      chk("rst_hresp", {30'b0, if8.hresp_s2}, 32'd0);
      chk("rst_hrdata", if8.hrdata_s2, 32'd0);
      chk("rst_paddr", if8.paddr, 32'd0);
      chk("rst_pwrite", {31'b0, if8.pwrite}, 32'd0);
      chk("rst_pwdata", if8.pwdata, 32'd0);
      chk("rst_psel", {24'b0, if8.psel}, 32'd0);
      chk("rst_penable", {31'b0, if8.penable}, 32'd0);
      chk("rst_psel_dut4", {28'b0, if4.psel}, 32'd0);
      chk("rst_hready_dut4", {31'b0, if4.hready_s2}, 32'd1);

      // Read slave 0, immediate pready.
      xfer(0, 32'h4000_0010, 1'b0, 32'h0, 2'b00, 32'hA5A5_0001, 4, 8'h01, 32'h0000_0010, 1);
      wait_done(0);
      @(negedge clk);

      // Write slave 3; hrdata keeps the previous read data.
      xfer(0, 32'h4003_0004, 1'b1, 32'hDEAD_BEEF, 2'b00, 32'hA5A5_0001, 4, 8'h08,
           32'h0000_0004, 1);
      wait_done(0);
      @(negedge clk);

      // Slave 2 stalls 5 cycles then pslverr; then a read accepted straight out of ERR2.
      wait_c[0] = 5; err_c[0] = 1'b1;
      xfer(0, 32'h4002_0008, 1'b0, 32'h0, 2'b01, 32'hA5A5_0003, 10, 8'h04, 32'h0000_0008, 6);
      wait_done(0);
      wait_c[0] = 0; err_c[0] = 1'b0;
      xfer(0, 32'h4007_FFFC, 1'b0, 32'h0, 2'b00, 32'hA5A5_0008, 4, 8'h80, 32'h0000_FFFC, 1);
      wait_done(0);
      @(negedge clk);

      // Back-to-back: second transfer issued during DONE.
      xfer(0, 32'h4001_0020, 1'b0, 32'h0, 2'b00, 32'hA5A5_0002, 4, 8'h02, 32'h0000_0020, 1);
      wait_done(0);
      xfer(0, 32'h4004_0100, 1'b1, 32'h1234_5678, 2'b00, 32'hA5A5_0002, 4, 8'h10,
           32'h0000_0100, 1);
      wait_done(0);
      @(negedge clk);

      // Reset pulsed during ACCESS aborts the transfer.
      wait_c[0] = 20;
      apb_q0.push_back('{psel: 8'h01, paddr: 32'h0, pwrite: 1'b0, pwdata: 32'h0, acc: 1});
      start(0, 32'h4000_0000, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      chk("midrst_psel", {24'b0, if8.psel}, 32'd0);
      chk("midrst_penable", {31'b0, if8.penable}, 32'd0);
      chk("midrst_hready", {31'b0, if8.hready_s2}, 32'd1);
      chk("midrst_hresp", {30'b0, if8.hresp_s2}, 32'd0);
      @(negedge clk);
      #1 rst_b = 1'b1;
      wait_c[0] = 0;
      @(negedge clk);

      // Recovery after reset.
      xfer(0, 32'h4005_0004, 1'b0, 32'h0, 2'b00, 32'hA5A5_0006, 4, 8'h20, 32'h0000_0004, 1);
      wait_done(0);
      @(negedge clk);

      // dut4: slave 1 never ready -> 4 ACCESS cycles then two-cycle ERROR.
      hang_c[1] = 1'b1;
      xfer(1, 32'h4001_0000, 1'b0, 32'h0, 2'b01, 32'h0, 8, 8'h02, 32'h0000_0000, 4);
      wait_done(1);
      hang_c[1] = 1'b0;
      @(negedge clk);

      // dut4: window 5 does not exist -> no APB phase, ERROR after LATCH.
      xfer(1, 32'h4005_0000, 1'b1, 32'hCAFE_F00D, 2'b01, 32'h0, 3, 8'h00, 32'h0, 0);
      wait_done(1);
      @(negedge clk);

      // dut4: normal read of slave 3.
      xfer(1, 32'h4003_0000, 1'b0, 32'h0, 2'b00, 32'hA5A5_0004, 4, 8'h08, 32'h0000_0000, 1);
      wait_done(1);
      repeat (3) @(negedge clk);

      chk("ahb_q0_drained", ahb_q0.size(), 32'd0);
      chk("ahb_q1_drained", ahb_q1.size(), 32'd0);
      chk("apb_q0_drained", apb_q0.size(), 32'd0);
      chk("apb_q1_drained", apb_q1.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
